// File: rtl/serial_out_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : serial_out_deserializer
// Purpose  : Receive side of the output-register serializer. Recovers bytes
//            from a one-wire framed stream (start 0, WIDTH data bits LSB
//            first, stop 1) and presents them on a valid/ready interface.
//            Flags framing errors (pulse) and overruns (sticky).
// Ports    : clk, rst_n (async, active low)
//            serial_in            framed stream, idles high
//            out_data/out_valid   last received byte / unconsumed flag
//            out_ready            consumer accepts when out_valid && out_ready
//            frame_err            one-clk pulse on a bad stop bit
//            overrun/overrun_clr  sticky byte-dropped flag and its clear
//            busy                 high while the receiver is mid-frame
//            parity_err           one-clk pulse on bad even parity
//                                 (only with SERIAL_DESER_PARITY_EN)
// Options  : define SERIAL_DESER_PARITY_EN to expect an even-parity bit
//            between the data bits and the stop bit.
// Revision : 1.0 - initial release
// ============================================================================
module serial_out_deserializer #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             serial_in,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             frame_err,
`ifdef SERIAL_DESER_PARITY_EN
  output logic             parity_err,
`endif
  output logic             overrun,
  input  logic             overrun_clr,
  output logic             busy
);

  localparam int c_half  = CLKS_PER_BIT / 2;
  localparam int c_cnt_w = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int c_bit_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_half = c_cnt_w'(c_half);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(CLKS_PER_BIT - 1);
  localparam logic [c_bit_w-1:0] c_bit_last = c_bit_w'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef SERIAL_DESER_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic                 r_sync1;
  logic                 r_sync2;
  logic                 w_s_in;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [c_cnt_w-1:0]   w_cnt_next;
  logic [c_bit_w-1:0]   r_bit;
  logic [c_bit_w-1:0]   w_bit_next;
  logic [WIDTH-1:0]     r_shift;
  logic                 w_sample;
  logic                 w_shift_en;
  logic                 w_stop_eval;
  logic                 w_par_bad;
  logic                 w_good;

  // Two-flop synchronizer; idles high so reset does not look like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= serial_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_s_in = r_sync2;

  // ---------------------------------------------------------------------------
  // FSM state register and bit-timing counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_bit   <= w_bit_next;
    end
  end

  // The cycle in which IDLE first sees s_in low is count 0 of the start bit,
  // so r_cnt is held at 0 in IDLE and the bit period runs from there. With
  // CLKS_PER_BIT==1 that detection cycle is itself the start-bit sample.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = (r_cnt == c_cnt_last) ? '0 : r_cnt + 1'b1;
    w_bit_next   = r_bit;
    w_sample     = (r_cnt == c_cnt_half);
    w_shift_en   = 1'b0;
    w_stop_eval  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_s_in) begin
          w_bit_next   = '0;
          w_state_next = w_sample ? S_DATA : S_START;
        end else begin
          w_cnt_next = '0;
        end
      end
      S_START: begin
        if (w_sample) begin
          if (w_s_in) begin
            w_state_next = S_IDLE;       // false start, no flags
            w_cnt_next   = '0;
          end else begin
            w_state_next = S_DATA;
            w_bit_next   = '0;
          end
        end
      end
      S_DATA: begin
        if (w_sample) begin
          w_shift_en = 1'b1;
          w_bit_next = r_bit + 1'b1;
          if (r_bit == c_bit_last) begin
`ifdef SERIAL_DESER_PARITY_EN
            w_state_next = S_PARITY;
`else
            w_state_next = S_STOP;
`endif
          end
        end
      end
`ifdef SERIAL_DESER_PARITY_EN
      S_PARITY: begin
        if (w_sample) w_state_next = S_STOP;
      end
`endif
      S_STOP: begin
        if (w_sample) begin
          w_stop_eval  = 1'b1;
          w_state_next = S_IDLE;
          w_cnt_next   = '0;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  assign busy = (r_state != S_IDLE);

`ifdef SERIAL_DESER_PARITY_EN
  logic r_par;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_par      <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (r_state == S_PARITY && w_sample) r_par <= w_s_in;
      parity_err <= w_stop_eval && w_par_bad;
    end
  end

  // Even parity: data bits plus parity bit must have an even count of ones.
  assign w_par_bad = ^{r_shift, r_par};
`else
  assign w_par_bad = 1'b0;
`endif

  assign w_good = w_stop_eval && w_s_in && !w_par_bad;

  // ---------------------------------------------------------------------------
  // Shift register, holding register and flags
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift   <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      // LSB arrives first: shifting in at the MSB leaves it at bit 0.
      if (w_shift_en) r_shift <= {w_s_in, r_shift[WIDTH-1:1]};

      frame_err <= w_stop_eval && !w_s_in;

      // A completion may reload in the same cycle the consumer accepts.
      if (w_good && (!out_valid || out_ready)) begin
        out_data  <= r_shift;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      // A dropped byte outranks a simultaneous clear.
      if (w_good && out_valid && !out_ready) overrun <= 1'b1;
      else if (overrun_clr)                 overrun <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_out_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_out_deserializer
// Purpose  : Self-checking bench for serial_out_deserializer. Frames are
//            queued with their due cycle (start edge + end-to-end latency);
//            a reference model applies the handshake/overrun rules at that
//            cycle and a compare process checks the outputs every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_out_deserializer;

  localparam int WIDTH        = 8;
  localparam int CLKS_PER_BIT = 2;
  localparam int HALF         = CLKS_PER_BIT / 2;
`ifdef SERIAL_DESER_PARITY_EN
  localparam int NBITS = WIDTH + 3;
`else
  localparam int NBITS = WIDTH + 2;
`endif
  // Start edge to out_valid high, in clocks.
  localparam int LAT = 2 + HALF + (NBITS - 1) * CLKS_PER_BIT + 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             serial_in;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             frame_err;
  logic             overrun;
  logic             overrun_clr;
  logic             busy;
`ifdef SERIAL_DESER_PARITY_EN
  logic             parity_err;
`endif

  serial_out_deserializer #(
    .WIDTH(WIDTH),
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .serial_in(serial_in),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .frame_err(frame_err),
`ifdef SERIAL_DESER_PARITY_EN
    .parity_err(parity_err),
`endif
    .overrun(overrun),
    .overrun_clr(overrun_clr),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    logic [7:0] data;
    bit         stop_ok;
    bit         par_ok;
  } frame_t;

  frame_t     q[$];
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  bit         chk_en = 1'b0;
  logic       m_valid = 1'b0;
  logic [7:0] m_data = '0;
  logic       m_ovr = 1'b0;
  logic       m_fe = 1'b0;
  logic       m_pe = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: a queued frame takes effect at its due edge.
  always @(posedge clk) begin : model
    frame_t ev;
    bit     ev_here;
    bit     ev_good;
    ev_here = 1'b0;
    ev      = '{due: 0, data: 8'h00, stop_ok: 1'b1, par_ok: 1'b1};
    cyc <= cyc + 1;
    if (!rst_n) begin
      q.delete();
      m_valid <= 1'b0;
      m_data  <= '0;
      m_ovr   <= 1'b0;
      m_fe    <= 1'b0;
      m_pe    <= 1'b0;
    end else begin
      if (q.size() > 0 && q[0].due == cyc + 1) begin
        ev      = q.pop_front();
        ev_here = 1'b1;
      end
      ev_good = ev_here && ev.stop_ok && ev.par_ok;
      m_fe <= ev_here && !ev.stop_ok;
      m_pe <= ev_here && !ev.par_ok;
      if (ev_good && (!m_valid || out_ready)) begin
        m_valid <= 1'b1;
        m_data  <= ev.data;
      end else if (m_valid && out_ready) begin
        m_valid <= 1'b0;
      end
      if (ev_good && m_valid && !out_ready) m_ovr <= 1'b1;
      else if (overrun_clr)                m_ovr <= 1'b0;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
      check("out_data",  {24'b0, out_data},  {24'b0, m_data});
      check("overrun",   {31'b0, overrun},   {31'b0, m_ovr});
      check("frame_err", {31'b0, frame_err}, {31'b0, m_fe});
`ifdef SERIAL_DESER_PARITY_EN
      check("parity_err", {31'b0, parity_err}, {31'b0, m_pe});
`endif
    end
  end

  // Drives one frame (or its first nbits bits); t0 is the start-edge cycle.
  task automatic send_frame(input logic [7:0] d, input bit stop_v, input bit par_flip,
                            input int nbits, output int t0);
    logic [15:0] bits;
    bits    = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < WIDTH; i++) bits[1+i] = d[i];
`ifdef SERIAL_DESER_PARITY_EN
    bits[WIDTH+1] = (^d) ^ par_flip;
`endif
    bits[NBITS-1] = stop_v;
    t0 = 0;
    for (int b = 0; b < nbits; b++) begin
      for (int c = 0; c < CLKS_PER_BIT; c++) begin
        @(negedge clk);
        serial_in = bits[b];
        if (b == 0 && c == 0) begin
          t0 = cyc;
          if (nbits == NBITS)
            q.push_back('{due: cyc + LAT, data: d, stop_ok: stop_v, par_ok: !par_flip});
        end
      end
    end
  endtask

  task automatic wait_to(input int target);
    while (cyc < target) @(negedge clk);
    check("cycle_align", cyc, target);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin : stim
    int t, t1, t2, t3;
    rst_n       = 1'b0;
    serial_in   = 1'b1;
    out_ready   = 1'b0;
    overrun_clr = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;

    // Idle line after reset.
    repeat (20) @(negedge clk);
    check("idle_valid", {31'b0, out_valid}, 0);
    check("idle_busy",  {31'b0, busy}, 0);
    check("idle_flags", {30'b0, frame_err, overrun}, 0);

    // 0xA5 with out_ready=1: visible exactly LAT clks after the start edge.
    out_ready = 1'b1;
    send_frame(8'hA5, 1'b1, 1'b0, NBITS, t);
    wait_to(t + 21);
    check("a5_early_valid", {31'b0, out_valid}, 0);
    check("a5_busy_stop",   {31'b0, busy}, 1);
    wait_to(t + 22);
    check("a5_valid", {31'b0, out_valid}, 1);
    check("a5_data",  {24'b0, out_data}, 32'hA5);
    check("a5_idle",  {31'b0, busy}, 0);
    wait_to(t + 23);
    check("a5_one_clk", {31'b0, out_valid}, 0);

    // Back-to-back frames with consumer stalled: first held, rest dropped.
    repeat (4) @(negedge clk);
    out_ready = 1'b0;
    send_frame(8'h3C, 1'b1, 1'b0, NBITS, t1);
    send_frame(8'hFF, 1'b1, 1'b0, NBITS, t2);
    send_frame(8'h00, 1'b1, 1'b0, NBITS, t3);
    check("b2b_spacing", t3 - t1, 2 * NBITS * CLKS_PER_BIT);
    wait_to(t3 + LAT + 1);
    check("ovr_set",   {31'b0, overrun}, 1);
    check("ovr_held",  {24'b0, out_data}, 32'h3C);
    check("ovr_valid", {31'b0, out_valid}, 1);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    check("ovr_clr",        {31'b0, overrun}, 0);
    check("ovr_clr_data",   {24'b0, out_data}, 32'h3C);
    check("ovr_clr_valid",  {31'b0, out_valid}, 1);
    out_ready = 1'b1;
    repeat (3) @(negedge clk);

    // Bad stop bit on 0x55, then a good 0x12.
    send_frame(8'h55, 1'b0, 1'b0, NBITS, t);
    @(negedge clk);
    serial_in = 1'b1;
    wait_to(t + LAT);
    check("fe_pulse",  {31'b0, frame_err}, 1);
    check("fe_valid",  {31'b0, out_valid}, 0);
    wait_to(t + LAT + 1);
    check("fe_one_clk", {31'b0, frame_err}, 0);
    repeat (4) @(negedge clk);
    send_frame(8'h12, 1'b1, 1'b0, NBITS, t);
    wait_to(t + LAT);
    check("after_fe_data",  {24'b0, out_data}, 32'h12);
    check("after_fe_valid", {31'b0, out_valid}, 1);

    // One-clk glitch: false start, no data, no flags.
    repeat (4) @(negedge clk);
    serial_in = 1'b0;
    @(negedge clk);
    serial_in = 1'b1;
    repeat (8) @(negedge clk);
    check("glitch_busy",  {31'b0, busy}, 0);
    check("glitch_valid", {31'b0, out_valid}, 0);

    // Reset mid-DATA of 0x81, then a clean 0x81.
    send_frame(8'h81, 1'b1, 1'b0, 4, t);
    #1 rst_n = 1'b0;
    serial_in = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_data",  {24'b0, out_data}, 0);
    check("rst_valid", {31'b0, out_valid}, 0);
    check("rst_busy",  {31'b0, busy}, 0);
    #1 rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("no_stale", {31'b0, out_valid}, 0);
    send_frame(8'h81, 1'b1, 1'b0, NBITS, t);
    wait_to(t + LAT);
    check("rx81_data",  {24'b0, out_data}, 32'h81);
    check("rx81_valid", {31'b0, out_valid}, 1);

`ifdef SERIAL_DESER_PARITY_EN
    repeat (4) @(negedge clk);
    send_frame(8'h81, 1'b1, 1'b1, NBITS, t);
    wait_to(t + LAT);
    check("pe_pulse", {31'b0, parity_err}, 1);
    check("pe_valid", {31'b0, out_valid}, 0);
`endif

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
